// File: rtl/write_once_reg_programmer_if.sv
// Bundle of the request, register-access and response signals used by the write-once programmer.
// The master modport is the programmer itself; the slave modport is the sequencer/register side.
interface write_once_reg_programmer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_lock;
    logic                  reg_write;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_status;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_retries;

    modport master (
        input  req_valid, req_data, req_lock, reg_rdata, rsp_ready,
        output req_ready, reg_write, reg_wdata, rsp_valid, rsp_status, rsp_rdata, rsp_retries
    );

    modport slave (
        output req_valid, req_data, req_lock, reg_rdata, rsp_ready,
        input  req_ready, reg_write, reg_wdata, rsp_valid, rsp_status, rsp_rdata, rsp_retries
    );
endinterface

// File: rtl/write_once_reg_programmer.sv
// Programs one write-once register: checks its lock bit, writes once, reads back and
// retries on mismatch, then reports OK / LOCKED / MISMATCH to the requester.
module write_once_reg_programmer #(
    parameter int DATA_WIDTH    = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int RETRY_MAX     = 3
) (
    input  logic                       Clk,
    input  logic                       ip_resetn,
    write_once_reg_programmer_if.master bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PRECHECK = 3'd1;
    localparam logic [2:0] WRITE    = 3'd2;
    localparam logic [2:0] SETTLE   = 3'd3;
    localparam logic [2:0] CHECK    = 3'd4;
    localparam logic [2:0] RESP     = 3'd5;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_LOCKED   = 2'b01;
    localparam logic [1:0] ST_MISMATCH = 2'b10;

    localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int RETRY_W = (RETRY_MAX > 1) ? $clog2(RETRY_MAX + 1) : 1;

    logic [2:0]            state;
    logic [CNT_W-1:0]      settle_cnt;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [1:0]            retries_sat;
    logic [DATA_WIDTH-1:1] data_q;
    logic                  lock_q;
    logic                  reg_write_q;
    logic [DATA_WIDTH-1:0] reg_wdata_q;
    logic [1:0]            status_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] expected;
    logic                  settle_done;
    logic                  can_retry;

    // The register reports the lock bit in bit 0, so the expected readback carries lock there.
    assign expected    = {data_q, lock_q};
    assign settle_done = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign can_retry   = (retry_cnt < RETRY_W'(RETRY_MAX)) && !bus.reg_rdata[0];

    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            retry_cnt   <= '0;
            retries_sat <= 2'd0;
            data_q      <= '0;
            lock_q      <= 1'b0;
            reg_write_q <= 1'b0;
            reg_wdata_q <= '0;
            status_q    <= ST_OK;
            rdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        data_q      <= bus.req_data[DATA_WIDTH-1:1];
                        lock_q      <= bus.req_lock;
                        retry_cnt   <= '0;
                        retries_sat <= 2'd0;
                        settle_cnt  <= '0;
                        state       <= PRECHECK;
                    end
                end
                PRECHECK: begin
                    if (settle_done) begin
                        settle_cnt <= '0;
                        rdata_q    <= bus.reg_rdata;
                        if (bus.reg_rdata[0]) begin
                            status_q <= ST_LOCKED;
                            state    <= RESP;
                        end else begin
                            reg_write_q <= 1'b1;
                            reg_wdata_q <= expected;
                            state       <= WRITE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    reg_write_q <= 1'b0;
                    settle_cnt  <= '0;
                    state       <= SETTLE;
                end
                SETTLE: begin
                    if (settle_done) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    rdata_q <= bus.reg_rdata;
                    if (bus.reg_rdata == expected) begin
                        status_q <= ST_OK;
                        state    <= RESP;
                    end else if (can_retry) begin
                        retry_cnt   <= retry_cnt + RETRY_W'(1);
                        retries_sat <= (retries_sat == 2'd3) ? 2'd3 : retries_sat + 2'd1;
                        reg_write_q <= 1'b1;
                        state       <= WRITE;
                    end else begin
                        status_q <= ST_MISMATCH;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state == IDLE);
    assign bus.rsp_valid   = (state == RESP);
    assign bus.reg_write   = reg_write_q;
    assign bus.reg_wdata   = reg_wdata_q;
    assign bus.rsp_status  = status_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_retries = retries_sat;
endmodule

// File: tb/tb_write_once_reg_programmer.sv
// Directed bench for write_once_reg_programmer with a behavioural write-once register that
// can force or corrupt readback to exercise the retry and mismatch paths.
module tb_write_once_reg_programmer;
    localparam int DW = 16;
    localparam int S  = 2;
    localparam int RM = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic          lock;
        logic          clear_model;
        logic          force_zero;
        logic          corrupt_first;
        logic [1:0]    exp_status;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_retries;
        int            exp_strobes;
        int            exp_latency;
        logic [DW-1:0] exp_wdata;
    } vector_t;

    logic Clk = 1'b0;
    logic ip_resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] reg_store;
    logic          model_clear = 1'b1;
    logic          force_zero = 1'b0;
    logic          corrupt_first = 1'b0;
    int            strobes = 0;
    int            strobe_base = 0;

    always #5 Clk = ~Clk;

    write_once_reg_programmer_if #(.DATA_WIDTH(DW)) bus ();

    write_once_reg_programmer #(
        .DATA_WIDTH(DW),
        .SETTLE_CYCLES(S),
        .RETRY_MAX(RM)
    ) dut (
        .Clk(Clk),
        .ip_resetn(ip_resetn),
        .bus(bus)
    );

    // Write-once register: accepts writes only while its lock bit (bit 0) is clear.
    always @(posedge Clk) begin
        if (model_clear) reg_store <= '0;
        else if (bus.reg_write && !reg_store[0]) reg_store <= bus.reg_wdata;
        if (bus.reg_write) strobes <= strobes + 1;
    end

    assign bus.reg_rdata = force_zero ? '0 :
                           (corrupt_first && (strobes - strobe_base) == 1) ? (reg_store ^ 16'h0100) :
                           reg_store;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic clear_model();
        @(negedge Clk);
        model_clear = 1'b1;
        @(negedge Clk);
        model_clear = 1'b0;
    endtask

    // Presents one request, then counts edges after the accepting edge until rsp_valid shows.
    task automatic apply_stimulus(input logic [DW-1:0] data, input logic lock, output int latency);
        @(negedge Clk);
        bus.req_valid = 1'b1;
        bus.req_data  = data;
        bus.req_lock  = lock;
        check_output("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        bus.req_valid = 1'b0;
        latency = 0;
        while (!bus.rsp_valid && latency < 200) begin
            @(negedge Clk);
            latency++;
        end
        if (latency >= 200) check_output("rsp_timeout", 32'd1, 32'd0);
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge Clk);
        bus.rsp_ready = 1'b0;
        check_output("rsp_valid_cleared", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_reg_write"}, {31'd0, bus.reg_write}, 32'd0);
        check_output({tag, "_reg_wdata"}, {16'd0, bus.reg_wdata}, 32'd0);
        check_output({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check_output({tag, "_rsp_status"}, {30'd0, bus.rsp_status}, 32'd0);
        check_output({tag, "_rsp_rdata"}, {16'd0, bus.rsp_rdata}, 32'd0);
        check_output({tag, "_rsp_retries"}, {30'd0, bus.rsp_retries}, 32'd0);
    endtask

    initial begin
        vector_t vectors[6];
        int latency;
        int waited;
        logic [DW-1:0] held_rdata;

        // Latency counts edges after the accepting edge N until rsp_valid is visible:
        // 2*S+2 means it is sampled high at edge N+2*S+3; LOCKED shows after S edges.
        vectors[0] = '{16'hA5A4, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'hA5A4, 2'd0, 1, 2*S+2, 16'hA5A4};
        vectors[1] = '{16'h1235, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h1235, 2'd0, 1, 2*S+2, 16'h1235};
        vectors[2] = '{16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 16'h1235, 2'd0, 0, S,     16'h1235};
        vectors[3] = '{16'hA5A4, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 16'h0000, 2'd3, 4, 2*S+2+3*(S+2), 16'hA5A4};
        vectors[4] = '{16'h3C3C, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 16'h3C3C, 2'd1, 2, 2*S+2+(S+2), 16'h3C3C};
        vectors[5] = '{16'h7771, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h7770, 2'd0, 1, 2*S+2, 16'h7770};

        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.req_lock  = 1'b0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge Clk);
        check_reset_outputs("in_reset");
        ip_resetn = 1'b1;
        model_clear = 1'b0;
        @(negedge Clk);
        check_output("req_ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            if (vectors[i].clear_model) clear_model();
            force_zero    = vectors[i].force_zero;
            corrupt_first = vectors[i].corrupt_first;
            strobe_base   = strobes;
            apply_stimulus(vectors[i].data, vectors[i].lock, latency);
            $display("[TB] vector %0d data=%h lock=%0d latency=%0d", i, vectors[i].data, vectors[i].lock, latency);
            check_output($sformatf("v%0d_latency", i), latency, vectors[i].exp_latency);
            check_output($sformatf("v%0d_status", i), {30'd0, bus.rsp_status}, {30'd0, vectors[i].exp_status});
            check_output($sformatf("v%0d_rdata", i), {16'd0, bus.rsp_rdata}, {16'd0, vectors[i].exp_rdata});
            check_output($sformatf("v%0d_retries", i), {30'd0, bus.rsp_retries}, {30'd0, vectors[i].exp_retries});
            check_output($sformatf("v%0d_strobes", i), strobes - strobe_base, vectors[i].exp_strobes);
            check_output($sformatf("v%0d_wdata", i), {16'd0, bus.reg_wdata}, {16'd0, vectors[i].exp_wdata});
            check_output($sformatf("v%0d_req_ready_busy", i), {31'd0, bus.req_ready}, 32'd0);
            finish_rsp();
            force_zero    = 1'b0;
            corrupt_first = 1'b0;
        end

        // Reset during SETTLE, then during the WRITE cycle itself.
        clear_model();
        @(negedge Clk);
        bus.req_valid = 1'b1;
        bus.req_data  = 16'hA5A4;
        bus.req_lock  = 1'b0;
        @(negedge Clk);
        bus.req_valid = 1'b0;
        waited = 0;
        while (!bus.reg_write && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        check_output("rst1_saw_write", {31'd0, bus.reg_write}, 32'd1);
        @(negedge Clk);
        ip_resetn = 1'b0;
        #1;
        check_reset_outputs("rst_settle");
        @(negedge Clk);
        ip_resetn = 1'b1;
        check_output("rst1_req_ready", {31'd0, bus.req_ready}, 32'd1);

        strobe_base = strobes;
        bus.req_valid = 1'b1;
        bus.req_data  = 16'h5A5A;
        @(negedge Clk);
        bus.req_valid = 1'b0;
        waited = 0;
        while (!bus.reg_write && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        check_output("rst2_saw_write", {31'd0, bus.reg_write}, 32'd1);
        ip_resetn = 1'b0;
        #1;
        check_reset_outputs("rst_write");
        check_output("rst2_no_strobe", strobes - strobe_base, 0);
        @(negedge Clk);
        ip_resetn = 1'b1;
        clear_model();
        strobe_base = strobes;
        apply_stimulus(16'hC3C2, 1'b0, latency);
        check_output("post_rst_latency", latency, 2*S+2);
        check_output("post_rst_status", {30'd0, bus.rsp_status}, 32'd0);
        check_output("post_rst_rdata", {16'd0, bus.rsp_rdata}, 32'h0000C3C2);
        check_output("post_rst_strobes", strobes - strobe_base, 1);
        finish_rsp();

        // Response back-pressure while a new request waits.
        clear_model();
        apply_stimulus(16'h2468, 1'b0, latency);
        check_output("bp_latency", latency, 2*S+2);
        held_rdata = bus.rsp_rdata;
        bus.req_valid = 1'b1;
        bus.req_data  = 16'h1111;
        bus.req_lock  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            check_output($sformatf("bp_valid_%0d", c), {31'd0, bus.rsp_valid}, 32'd1);
            check_output($sformatf("bp_ready_%0d", c), {31'd0, bus.req_ready}, 32'd0);
            check_output($sformatf("bp_rdata_%0d", c), {16'd0, bus.rsp_rdata}, {16'd0, held_rdata});
            check_output($sformatf("bp_status_%0d", c), {30'd0, bus.rsp_status}, 32'd0);
        end
        check_output("bp_rdata_value", {16'd0, held_rdata}, 32'h00002468);
        bus.rsp_ready = 1'b1;
        @(posedge Clk);
        #1;
        bus.rsp_ready = 1'b0;
        check_output("bp_after_hs_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_output("bp_after_hs_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge Clk);
        #1;
        check_output("bp_accepted_next", {31'd0, bus.req_ready}, 32'd0);
        @(negedge Clk);
        bus.req_valid = 1'b0;
        waited = 0;
        while (!bus.rsp_valid && waited < 200) begin
            @(negedge Clk);
            waited++;
        end
        check_output("bp_second_status", {30'd0, bus.rsp_status}, 32'd0);
        check_output("bp_second_rdata", {16'd0, bus.rsp_rdata}, 32'h00001110);
        finish_rsp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
